// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: 64-bit packed raster in, 64-bit packed raster out.
// Pixels move one per cycle through two line buffers and a 3x3 window, then a 2-stage datapath.
module sobel_stream #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_mode,
    input  logic [7:0]  i_thresh,
    input  logic        i_pix_valid,
    input  logic [63:0] i_pix_data,
    output logic        o_pix_ack,
    output logic        o_sobel_valid,
    output logic [63:0] o_sobel_data,
    input  logic        i_sobel_ack,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NWORDS = NPIX / 8;
    localparam int NSTEPS = NPIX + IMG_W + 1;
    localparam int SW     = $clog2(NSTEPS + 1);
    localparam int WW     = $clog2(NWORDS + 1);
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state_q;
    logic             mode_q, frameDone_q;
    logic [7:0]       thresh_q;
    logic [WW-1:0]    wordsIn_q, wordsOut_q;
    logic [SW-1:0]    step_q;
    logic [3:0]       unpCnt_q;
    logic [63:0]      unpData_q;
    logic [CW-1:0]    col_q, outCol_q;
    logic [RW-1:0]    outRow_q;
    logic             winValid_q, winBorder_q;
    logic             s1Valid_q, s1Border_q, s2Valid_q;
    logic signed [10:0] gx_q, gy_q;
    logic [7:0]       s2Pix_q;
    logic [2:0]       pkCnt_q;
    logic [55:0]      pkData_q;
    logic [63:0]      fifo_q [4];
    logic [1:0]       wrPtr_q, rdPtr_q;
    logic [2:0]       fifoCnt_q;
    logic [7:0]       lb0_q [IMG_W];
    logic [7:0]       lb1_q [IMG_W];
    logic [7:0]       win_q [3][3];

    logic busy, adv, fromInput, srcAvail, doStep, emit, outBorder, accept, push, pop;
    logic [7:0] stepPix;

    // A step shifts one pixel into the window; step s centres the window on output pixel s-IMG_W-1.
    // Steps past the last input pixel feed dummies, since everything they centre on is border.
    always_comb begin
        busy      = (state_q != IDLE);
        adv       = !(s2Valid_q && (pkCnt_q == 3'd7) && (fifoCnt_q == 3'd4));
        fromInput = (step_q < SW'(NPIX));
        srcAvail  = fromInput ? (unpCnt_q != 4'd0) : (step_q < SW'(NSTEPS));
        doStep    = busy && adv && srcAvail;
        stepPix   = fromInput ? unpData_q[7:0] : 8'h00;
        emit      = (step_q >= SW'(IMG_W + 1));
        outBorder = (outRow_q == '0) || (outRow_q == RW'(IMG_H - 1)) ||
                    (outCol_q == '0) || (outCol_q == CW'(IMG_W - 1));
        o_pix_ack = (state_q == RUN) && (unpCnt_q == 4'd0) && adv;
        accept    = i_pix_valid && o_pix_ack;
        push      = adv && s2Valid_q && (pkCnt_q == 3'd7);
        pop       = (fifoCnt_q != 3'd0) && i_sobel_ack;
    end

    function automatic logic signed [10:0] px(input logic [7:0] p);
        return signed'({3'b000, p});
    endfunction

    logic signed [10:0] gxD, gyD;
    logic [10:0] absGx, absGy, sumAbs;
    logic [9:0]  mag;
    logic [7:0]  satPix, thrPix, s2PixD;

    always_comb begin
        gxD    = (px(win_q[0][2]) + (px(win_q[1][2]) <<< 1) + px(win_q[2][2]))
               - (px(win_q[0][0]) + (px(win_q[1][0]) <<< 1) + px(win_q[2][0]));
        gyD    = (px(win_q[2][0]) + (px(win_q[2][1]) <<< 1) + px(win_q[2][2]))
               - (px(win_q[0][0]) + (px(win_q[0][1]) <<< 1) + px(win_q[0][2]));
        absGx  = gx_q[10] ? -gx_q : gx_q;
        absGy  = gy_q[10] ? -gy_q : gy_q;
        sumAbs = absGx + absGy;
        mag    = 10'(sumAbs >> 1);
        satPix = (mag > 10'd255) ? 8'hFF : mag[7:0];
        thrPix = (mag > {2'b00, thresh_q}) ? 8'h00 : 8'hFF;
        s2PixD = s1Border_q ? (mode_q ? 8'h00 : 8'hFF) : (mode_q ? satPix : thrPix);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            thresh_q    <= 8'h00;
            wordsIn_q   <= '0;
            wordsOut_q  <= '0;
            frameDone_q <= 1'b0;
        end else begin
            frameDone_q <= 1'b0;
            case (state_q)
                IDLE: if (i_start) begin
                    state_q    <= RUN;
                    mode_q     <= i_mode;
                    thresh_q   <= i_thresh;
                    wordsIn_q  <= '0;
                    wordsOut_q <= '0;
                end
                RUN: if (accept) begin
                    wordsIn_q <= wordsIn_q + 1'b1;
                    if (wordsIn_q == WW'(NWORDS - 1)) state_q <= FLUSH;
                end
                FLUSH: if (pop && wordsOut_q == WW'(NWORDS - 1)) begin
                    state_q     <= IDLE;
                    frameDone_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (pop && busy) wordsOut_q <= wordsOut_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            step_q      <= '0;
            unpCnt_q    <= '0;
            unpData_q   <= '0;
            col_q       <= '0;
            outRow_q    <= '0;
            outCol_q    <= '0;
            winValid_q  <= 1'b0;
            winBorder_q <= 1'b0;
            s1Valid_q   <= 1'b0;
            s1Border_q  <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            s2Valid_q   <= 1'b0;
            s2Pix_q     <= '0;
            pkCnt_q     <= '0;
            pkData_q    <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCnt_q   <= '0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
        end else if (state_q == IDLE && i_start) begin
            step_q     <= '0;
            unpCnt_q   <= '0;
            col_q      <= '0;
            outRow_q   <= '0;
            outCol_q   <= '0;
            winValid_q <= 1'b0;
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            pkCnt_q    <= '0;
        end else begin
            if (accept) begin
                unpData_q <= i_pix_data;
                unpCnt_q  <= 4'd8;
            end
            if (doStep) begin
                step_q <= step_q + 1'b1;
                if (fromInput) begin
                    unpData_q <= {8'h00, unpData_q[63:8]};
                    unpCnt_q  <= unpCnt_q - 1'b1;
                end
                col_q       <= (col_q == CW'(IMG_W - 1)) ? '0 : col_q + 1'b1;
                winValid_q  <= emit;
                winBorder_q <= outBorder;
                if (emit) begin
                    if (outCol_q == CW'(IMG_W - 1)) begin
                        outCol_q <= '0;
                        outRow_q <= outRow_q + 1'b1;
                    end else begin
                        outCol_q <= outCol_q + 1'b1;
                    end
                end
            end else if (adv) begin
                winValid_q <= 1'b0;
            end
            if (adv) begin
                s1Valid_q  <= winValid_q;
                s1Border_q <= winBorder_q;
                gx_q       <= gxD;
                gy_q       <= gyD;
                s2Valid_q  <= s1Valid_q;
                s2Pix_q    <= s2PixD;
                if (s2Valid_q) begin
                    if (pkCnt_q == 3'd7) begin
                        pkCnt_q <= '0;
                    end else begin
                        pkData_q[{pkCnt_q, 3'b000} +: 8] <= s2Pix_q;
                        pkCnt_q <= pkCnt_q + 1'b1;
                    end
                end
            end
            if (push) begin
                fifo_q[wrPtr_q] <= {s2Pix_q, pkData_q};
                wrPtr_q         <= wrPtr_q + 1'b1;
            end
            if (pop) rdPtr_q <= rdPtr_q + 1'b1;
            fifoCnt_q <= fifoCnt_q + {2'b00, push} - {2'b00, pop};
        end
    end

    // Line buffers hold the two previous rows at the current column; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (doStep) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= stepPix;
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_q[col_q];
            win_q[1][2] <= lb0_q[col_q];
            win_q[2][2] <= stepPix;
        end
    end

    assign o_sobel_valid = (fifoCnt_q != 3'd0);
    assign o_sobel_data  = o_sobel_valid ? fifo_q[rdPtr_q] : 64'h0;
    assign o_busy        = busy;
    assign o_frame_done  = frameDone_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on a 16x4 frame: directed table vectors,
// randomized images checked against a plain-arithmetic Sobel model, and a mid-frame reset.
module tb_sobel_stream;

    localparam int W     = 16;
    localparam int H     = 4;
    localparam int NW    = W * H / 8;
    localparam int LIMIT = 3000;

    localparam logic [NW*64-1:0] ALL_FF  = {NW{64'hFFFF_FFFF_FFFF_FFFF}};
    localparam logic [NW*64-1:0] STEP_M1 = {64'h0, 64'h0,
                                            64'h0000_0000_0000_00FF, 64'hFF00_0000_0000_0000,
                                            64'h0000_0000_0000_00FF, 64'hFF00_0000_0000_0000,
                                            64'h0, 64'h0};
    localparam logic [NW*64-1:0] STEP_M0 = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                            64'hFFFF_FFFF_FFFF_FF00, 64'h00FF_FFFF_FFFF_FFFF,
                                            64'hFFFF_FFFF_FFFF_FF00, 64'h00FF_FFFF_FFFF_FFFF,
                                            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    typedef struct {
        int               pattern;
        logic             mode;
        logic [7:0]       thresh;
        int               stall;
        bit               midChange;
        bit               startSpam;
        bit               useTable;
        logic [NW*64-1:0] expTable;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_mode = 1'b0;
    logic [7:0]  i_thresh = 8'h00;
    logic        i_pix_valid = 1'b0;
    logic [63:0] i_pix_data = 64'h0;
    logic        o_pix_ack;
    logic        o_sobel_valid;
    logic [63:0] o_sobel_data;
    logic        i_sobel_ack = 1'b0;
    logic        o_busy;
    logic        o_frame_done;

    vec_t        vecs [10];
    logic [7:0]  img [H][W];
    logic [63:0] expW [NW];
    logic [63:0] gotW [NW];
    int          vecCount = 0;
    int          missCount = 0;
    int          gotCount, doneCount;
    bit          extraOut;

    sobel_stream #(.IMG_W(W), .IMG_H(H)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode), .i_thresh(i_thresh),
        .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ack(o_pix_ack),
        .o_sobel_valid(o_sobel_valid), .o_sobel_data(o_sobel_data), .i_sobel_ack(i_sobel_ack),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] wordOf(int idx);
        logic [63:0] w;
        int r, c0;
        r  = (idx * 8) / W;
        c0 = (idx * 8) % W;
        for (int k = 0; k < 8; k++) w[k*8 +: 8] = img[r][c0 + k];
        return w;
    endfunction

    function automatic int px(int r, int c);
        return int'(img[r][c]);
    endfunction

    task automatic fillImage(int pattern);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pattern)
                    0:       img[r][c] = 8'h40;
                    1:       img[r][c] = (c < 8) ? 8'h00 : 8'hFF;
                    2:       img[r][c] = 8'($urandom_range(0, 255));
                    default: img[r][c] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                endcase
    endtask

    task automatic modelFrame(logic mode, logic [7:0] thr);
        int gx, gy, mag, pix, idx;
        for (int i = 0; i < NW; i++) expW[i] = 64'h0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
                    pix = mode ? 0 : 255;
                end else begin
                    gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1))
                       - (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
                    gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1))
                       - (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
                    mag = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
                    if (mode) pix = (mag > 255) ? 255 : mag;
                    else      pix = (mag > int'(thr)) ? 0 : 255;
                end
                idx = r * W + c;
                expW[idx / 8][(idx % 8) * 8 +: 8] = 8'(pix);
            end
        end
    endtask

    task automatic checkOutput(string name, logic [63:0] got, logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One full frame: random input gaps and output back-pressure, optional long ack stall.
    task automatic applyStimulus(logic mode, logic [7:0] thr, int stall, bit midChange, bit startSpam);
        int inIdx, cyc, stallLeft;
        bit stallUsed;
        for (int i = 0; i < NW; i++) gotW[i] = 'x;
        inIdx = 0; gotCount = 0; doneCount = 0; extraOut = 0;
        cyc = 0; stallLeft = 0; stallUsed = 0;
        @(negedge i_clk);
        i_mode = mode; i_thresh = thr; i_start = 1'b1;
        @(negedge i_clk);
        i_start = startSpam;
        while (gotCount < NW && cyc < LIMIT) begin
            if (o_frame_done) doneCount++;
            i_pix_valid = (inIdx < NW) && ($urandom_range(0, 3) != 0);
            i_pix_data  = i_pix_valid ? wordOf(inIdx) : {$urandom, $urandom};
            if (i_pix_valid && o_pix_ack) inIdx++;
            if (midChange && inIdx >= 2) begin
                i_thresh = 8'h00;
                i_mode   = ~mode;
            end
            if (stall > 0 && !stallUsed && o_sobel_valid) begin
                stallLeft = stall;
                stallUsed = 1;
            end
            if (stallLeft > 0) begin
                i_sobel_ack = 1'b0;
                stallLeft--;
            end else begin
                i_sobel_ack = ($urandom_range(0, 4) != 0);
            end
            if (i_sobel_ack && o_sobel_valid) begin
                gotW[gotCount] = o_sobel_data;
                gotCount++;
            end
            i_start = startSpam && (gotCount < NW);
            @(negedge i_clk);
            cyc++;
        end
        i_start = 1'b0;
        repeat (6) begin
            if (o_frame_done) doneCount++;
            if (o_sobel_valid) extraOut = 1;
            i_pix_valid = 1'b0;
            i_sobel_ack = 1'b0;
            @(negedge i_clk);
        end
    endtask

    task automatic checkFrame(string tag);
        for (int w = 0; w < NW; w++) checkOutput($sformatf("%s word%0d", tag, w), gotW[w], expW[w]);
        checkOutput({tag, " wordCount"}, 64'(gotCount), 64'(NW));
        checkOutput({tag, " frameDone"}, 64'(doneCount), 64'd1);
        checkOutput({tag, " idleAfter"}, {62'h0, o_busy, extraOut}, 64'h0);
    endtask

    initial begin
        int inIdx, cyc;
        vecs[0] = '{pattern: 0, mode: 1'b0, thresh: 8'd60,  stall: 0,  midChange: 1'b0, startSpam: 1'b0, useTable: 1'b1, expTable: ALL_FF};
        vecs[1] = '{pattern: 1, mode: 1'b1, thresh: 8'd0,   stall: 0,  midChange: 1'b0, startSpam: 1'b0, useTable: 1'b1, expTable: STEP_M1};
        vecs[2] = '{pattern: 1, mode: 1'b0, thresh: 8'd255, stall: 0,  midChange: 1'b1, startSpam: 1'b0, useTable: 1'b1, expTable: STEP_M0};
        vecs[3] = '{pattern: 1, mode: 1'b1, thresh: 8'd0,   stall: 50, midChange: 1'b0, startSpam: 1'b0, useTable: 1'b1, expTable: STEP_M1};
        vecs[4] = '{pattern: 1, mode: 1'b1, thresh: 8'd0,   stall: 0,  midChange: 1'b0, startSpam: 1'b1, useTable: 1'b1, expTable: STEP_M1};
        vecs[5] = '{pattern: 2, mode: 1'b0, thresh: 8'd100, stall: 0,  midChange: 1'b0, startSpam: 1'b0, useTable: 1'b0, expTable: '0};
        vecs[6] = '{pattern: 2, mode: 1'b1, thresh: 8'd0,   stall: 0,  midChange: 1'b1, startSpam: 1'b0, useTable: 1'b0, expTable: '0};
        vecs[7] = '{pattern: 3, mode: 1'b1, thresh: 8'd0,   stall: 30, midChange: 1'b0, startSpam: 1'b0, useTable: 1'b0, expTable: '0};
        vecs[8] = '{pattern: 3, mode: 1'b0, thresh: 8'd200, stall: 0,  midChange: 1'b0, startSpam: 1'b0, useTable: 1'b0, expTable: '0};
        vecs[9] = '{pattern: 2, mode: 1'b0, thresh: 8'd30,  stall: 0,  midChange: 1'b0, startSpam: 1'b1, useTable: 1'b0, expTable: '0};

        #1;
        checkOutput("resetOutputs", {60'h0, o_pix_ack, o_sobel_valid, o_busy, o_frame_done}, 64'h0);
        checkOutput("resetData", o_sobel_data, 64'h0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;

        for (int v = 0; v < 10; v++) begin
            fillImage(vecs[v].pattern);
            if (vecs[v].useTable)
                for (int w = 0; w < NW; w++) expW[w] = vecs[v].expTable[w*64 +: 64];
            else
                modelFrame(vecs[v].mode, vecs[v].thresh);
            applyStimulus(vecs[v].mode, vecs[v].thresh, vecs[v].stall, vecs[v].midChange, vecs[v].startSpam);
            checkFrame($sformatf("v%0d", v));
        end

        // Abort a frame with reset after three input words, then run a clean frame.
        fillImage(2);
        @(negedge i_clk);
        i_mode = 1'b0; i_thresh = 8'd50; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        inIdx = 0; cyc = 0;
        while (inIdx < 3 && cyc < 200) begin
            i_pix_valid = 1'b1;
            i_pix_data  = wordOf(inIdx);
            i_sobel_ack = 1'b1;
            if (o_pix_ack) inIdx++;
            @(negedge i_clk);
            cyc++;
        end
        i_pix_valid = 1'b0;
        checkOutput("rstFeed", 64'(inIdx), 64'd3);
        checkOutput("rstBusyBefore", {63'h0, o_busy}, 64'h1);
        i_rst = 1'b0;
        #1;
        checkOutput("rstOutputs", {60'h0, o_pix_ack, o_sobel_valid, o_busy, o_frame_done}, 64'h0);
        checkOutput("rstData", o_sobel_data, 64'h0);
        @(negedge i_clk);
        i_rst = 1'b1;
        fillImage(2);
        modelFrame(1'b1, 8'd0);
        applyStimulus(1'b1, 8'd0, 0, 1'b0, 1'b0);
        checkFrame("afterRst");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 SHALL have parameter IMG_W, default 512: pixels per line; multiple of 8; at least 16.
REQ-002 SHALL have parameter IMG_H, default 512: lines per frame; at least 3.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic rises on it.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_start, input, 1 bit: frame start request; sampled in IDLE only.
REQ-006 SHALL have port i_mode, input, 1 bit: 0 = binary threshold output, 1 = saturated magnitude output.
REQ-007 SHALL have port i_thresh, input, 8 bits: binary threshold.
REQ-008 SHALL have ports i_pix_valid (input, 1 bit), i_pix_data (input, 64 bits) and o_pix_ack (output, 1 bit): raster input stream, 8 pixels per word, pixel k at bits [8k+7:8k].
REQ-009 SHALL have ports o_sobel_valid (output, 1 bit), o_sobel_data (output, 64 bits) and i_sobel_ack (input, 1 bit): raster output stream, same packing as the input.
REQ-010 SHALL have port o_busy, output, 1 bit: high in RUN or FLUSH.
REQ-011 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-012 SHALL use FSM states IDLE, RUN, FLUSH; IDLE -> RUN on i_start; RUN -> FLUSH after IMG_W*IMG_H/8 input words are accepted; FLUSH -> IDLE when the last output word is accepted.
REQ-013 SHALL latch i_mode and i_thresh on IDLE -> RUN; changes mid-frame SHALL have no effect.
REQ-014 SHALL ignore i_start outside IDLE.
REQ-015 SHALL accept an input word when i_pix_valid and o_pix_ack are both high; o_pix_ack SHALL be high only in RUN, with the unpack register empty and the pipeline not stalled.
REQ-016 SHALL deassert o_pix_ack in IDLE and FLUSH; words offered then are not consumed.
REQ-017 SHALL unpack each input word into 1 pixel per cycle and shift pixels through two internal IMG_W x 8 rolling line buffers plus a 3x3 window.
REQ-018 SHALL compute Gx = (p13+2*p23+p33)-(p11+2*p21+p31) and Gy = (p31+2*p32+p33)-(p11+2*p12+p13), each 11-bit signed, with pRC meaning row R, column C.
REQ-019 SHALL compute mag = (|Gx|+|Gy|)>>1 as a 10-bit unsigned value, with no overflow at any input.
REQ-020 SHALL output, in mode 0, 8'h00 when mag > thresh, else 8'hFF; in mode 1, it SHALL output min(mag,255).
REQ-021 SHALL force border pixels (row 0, row IMG_H-1, column 0, column IMG_W-1) to the background value: 8'hFF in mode 0, 8'h00 in mode 1.
REQ-022 SHALL produce output pixel (r,c) for 1<=r<=IMG_H-2 once input pixel (r+1,c+1) is in the window.
REQ-023 SHALL emit output row IMG_H-1 during FLUSH with no further input.
REQ-024 SHALL emit exactly IMG_W*IMG_H/8 output words per frame, in raster order.
REQ-025 SHALL have an arithmetic pipeline of 2 cycles from window to pixel, followed by an 8-pixel packer and a 4-word output FIFO.
REQ-026 SHALL hold o_sobel_valid high when the output FIFO is not empty, with o_sobel_data showing the FIFO head; the FIFO SHALL pop on o_sobel_valid and i_sobel_ack.
REQ-027 SHALL stall the unpacker, window and pipeline together when the FIFO is full or the packer cannot write; no pixel SHALL be lost or duplicated.
REQ-028 SHALL ignore i_sobel_ack when the FIFO is empty.
REQ-029 SHALL reset the line-buffer column counter at every line end and the row counter at every frame start.
REQ-030 SHALL pulse o_frame_done in the cycle after the final output word is popped, at the same time as the FLUSH -> IDLE transition.

Reset
REQ-031 SHALL, while i_rst is low, set state IDLE, clear all counters, empty the FIFO and packer, and drive o_pix_ack, o_sobel_valid, o_busy and o_frame_done to 0 and o_sobel_data to 0, regardless of clock.
REQ-032 SHALL discard a partially processed frame on reset mid-frame; line-buffer contents need not be cleared.

Verification (IMG_W=16, IMG_H=4; 8 words in, 8 words out)
REQ-033 Uniform 0x40 frame, mode 0, thresh 60 -> all 8 output words 64'hFFFF_FFFF_FFFF_FFFF; one o_frame_done pulse; o_busy low afterwards.
REQ-034 Vertical step (columns 0-7 = 0x00, columns 8-15 = 0xFF), mode 1 -> rows 1-2 have 0xFF at columns 7 and 8 (Gx=1020, mag=510, saturated) and 0x00 elsewhere; rows 0 and 3 all 0x00.
REQ-035 Same step, mode 0, thresh 255 -> rows 1-2 have 0x00 at columns 7 and 8 and 0xFF elsewhere; i_thresh changed to 0 mid-frame changes nothing.
REQ-036 i_sobel_ack held low for 50 cycles mid-frame -> o_pix_ack drops; output stays bit-identical to the no-stall run; word count is 8.
REQ-037 i_rst pulsed low after 3 input words -> all outputs 0 at once; a following i_start plus a full frame gives the correct 8 words.
REQ-038 i_start asserted during RUN and FLUSH -> no effect; exactly one frame is output.
